// File: rtl/bus_arbiter_pkg.sv
// bus_pkg: shared definitions for the two-master bus arbiter.
//   state_t         - arbiter FSM states
//   M0 / M1         - master identifiers as carried on owner / winner
//   RD_LATENCY_MAX  - largest supported slave read latency
//   CNT_W           - width of the read-latency down-counter
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int RD_LATENCY_MAX = 4;
    localparam int CNT_W          = $clog2(RD_LATENCY_MAX + 1);

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: bundle of the two master request ports and the slave port.
//   m0_* / m1_*  : req, addr, wdata, wstrb in; ack, rdata out (arbiter view)
//   s_*          : addr, wdata, wstrb, rstrb out; rdata in (arbiter view)
//   owner, busy  : arbiter status
// Modports:
//   slave  - the arbiter itself (it serves the masters and drives the slave bus)
//   master - the surrounding system (requesters plus the downstream slave)
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  m0_req;
    logic [ADDR_W-1:0]     m0_addr;
    logic [DATA_W-1:0]     m0_wdata;
    logic [DATA_W/8-1:0]   m0_wstrb;
    logic                  m0_ack;
    logic [DATA_W-1:0]     m0_rdata;

    logic                  m1_req;
    logic [ADDR_W-1:0]     m1_addr;
    logic [DATA_W-1:0]     m1_wdata;
    logic [DATA_W/8-1:0]   m1_wstrb;
    logic                  m1_ack;
    logic [DATA_W-1:0]     m1_rdata;

    logic [ADDR_W-1:0]     s_addr;
    logic [DATA_W-1:0]     s_wdata;
    logic [DATA_W/8-1:0]   s_wstrb;
    logic                  s_rstrb;
    logic [DATA_W-1:0]     s_rdata;

    logic                  owner;
    logic                  busy;

    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_wstrb,
        input  m1_req, m1_addr, m1_wdata, m1_wstrb,
        input  s_rdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output s_addr, s_wdata, s_wstrb, s_rstrb,
        output owner, busy
    );

    modport master (
        output m0_req, m0_addr, m0_wdata, m0_wstrb,
        output m1_req, m1_addr, m1_wdata, m1_wstrb,
        output s_rdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  s_addr, s_wdata, s_wstrb, s_rstrb,
        input  owner, busy
    );
endinterface

// File: rtl/bus_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way grant selection.
//   i_req[1:0]    in  request per master
//   i_last        in  master granted most recently
//   i_fixed_prio  in  1 = master 0 always wins contention
//   o_valid       out some request is present
//   o_winner      out selected master (meaningful when o_valid)
module rr_pick2
    import bus_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_fixed_prio,
    output logic       o_valid,
    output logic       o_winner
);

    always_comb begin
        o_valid  = |i_req;
        o_winner = M0;
        if (i_req == 2'b11) begin
            // Contention: round-robin hands the grant to whoever did not win last.
            o_winner = i_fixed_prio ? M0 : ~i_last;
        end else if (i_req[1]) begin
            o_winner = M1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one single-beat slave bus between two masters.
//   clk   in  clock
//   rst   in  asynchronous active-high reset
//   bus   slave modport of bus_arbiter_if (master requests, slave bus, status)
// Parameters: ADDR_W, DATA_W, RD_LATENCY (1..RD_LATENCY_MAX), FIXED_PRIO.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic           clk,
    input  logic           rst,
    bus_arbiter_if.slave   bus
);

    localparam int                STRB_W = DATA_W / 8;
    localparam logic [CNT_W-1:0]  LAT    = CNT_W'(RD_LATENCY);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_owner;
    logic                r_last;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_m0_ack;
    logic                r_m1_ack;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;

    logic                w_valid;
    logic                w_winner;
    logic                w_is_write;
    logic                w_capture;

    rr_pick2 u_pick (
        .i_req        ({bus.m1_req, bus.m0_req}),
        .i_last       (r_last),
        .i_fixed_prio (FIXED_PRIO != 0),
        .o_valid      (w_valid),
        .o_winner     (w_winner)
    );

    assign w_is_write = |r_wstrb;
    assign w_capture  = (r_state == WAIT) && (w_next_state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_next_state = ISSUE;
            ISSUE:   w_next_state = w_is_write ? RESP : WAIT;
            WAIT:    if (r_cnt == CNT_W'(1)) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.s_addr  = '0;
        bus.s_wdata = '0;
        bus.s_wstrb = '0;
        bus.s_rstrb = 1'b0;
        if (r_state != IDLE) begin
            bus.s_addr  = r_addr;
            bus.s_wdata = r_wdata;
        end
        if (r_state == ISSUE) begin
            if (w_is_write) begin
                bus.s_wstrb = r_wstrb;
            end else begin
                bus.s_rstrb = 1'b1;
            end
        end
    end

    // Request latch, latency counter, last pointer and the registered master-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner    <= M0;
            r_last     <= M1;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_owner <= w_winner;
                        r_addr  <= (w_winner == M1) ? bus.m1_addr  : bus.m0_addr;
                        r_wdata <= (w_winner == M1) ? bus.m1_wdata : bus.m0_wdata;
                        r_wstrb <= (w_winner == M1) ? bus.m1_wstrb : bus.m0_wstrb;
                    end
                end
                ISSUE: begin
                    if (!w_is_write) r_cnt <= LAT;
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                RESP: begin
                    r_last <= r_owner;
                end
                default: ;
            endcase

            r_busy   <= (w_next_state != IDLE);
            r_m0_ack <= (w_next_state == RESP) && (r_owner == M0);
            r_m1_ack <= (w_next_state == RESP) && (r_owner == M1);
            // Read data is taken straight into the owner's output register on the
            // last WAIT cycle; writes (and every non-RESP cycle) present zero.
            r_m0_rdata <= (w_capture && r_owner == M0) ? bus.s_rdata : '0;
            r_m1_rdata <= (w_capture && r_owner == M1) ? bus.s_rdata : '0;
        end
    end

    assign bus.m0_ack   = r_m0_ack;
    assign bus.m1_ack   = r_m1_ack;
    assign bus.m0_rdata = r_m0_rdata;
    assign bus.m1_rdata = r_m1_rdata;
    assign bus.owner    = r_owner;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_bus_arbiter.sv
`timescale 1ns/1ps
// Three arbiter instances run the same stimulus side by side:
//   env 0: RD_LATENCY=1, round-robin; env 1: RD_LATENCY=3, round-robin;
//   env 2: RD_LATENCY=1, fixed priority.
// A timestamp model predicts, per grant, the strobe cycle and the ack cycle.
module tb_bus_arbiter;

    localparam int NENV = 3;

    typedef enum int {MD_IDLE, MD_RAND, MD_BOTHRD, MD_DIR} mode_t;

    typedef struct {
        int          cyc;
        logic        m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  wstrb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    mode_t       mode = MD_IDLE;
    int          dir_seq [2];
    logic [31:0] dir_addr [2];
    logic [31:0] dir_wdata [2];
    logic [3:0]  dir_wstrb [2];
    logic        dir_drop [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int env, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s env%0d cyc %0d: got %0h want %0h", nm, env, cyc, act, exp);
        end
    endtask

    // Downstream slave contents: fixed value at 0x10, address-derived elsewhere.
    function automatic logic [31:0] slave_data(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h1234_5678;
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0000;
    endfunction

    for (genvar g = 0; g < NENV; g++) begin : ge
        localparam int L  = (g == 1) ? 3 : 1;
        localparam int FP = (g == 2) ? 1 : 0;

        bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

        bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(L), .FIXED_PRIO(FP)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        logic        req [2];
        logic [31:0] addr [2];
        logic [31:0] wdata [2];
        logic [3:0]  wstrb [2];
        logic        pend [2];
        logic [31:0] sl_rdata;

        assign bus.m0_req   = req[0];
        assign bus.m0_addr  = addr[0];
        assign bus.m0_wdata = wdata[0];
        assign bus.m0_wstrb = wstrb[0];
        assign bus.m1_req   = req[1];
        assign bus.m1_addr  = addr[1];
        assign bus.m1_wdata = wdata[1];
        assign bus.m1_wstrb = wstrb[1];
        assign bus.s_rdata  = sl_rdata;

        // Master drivers: one outstanding transaction per master, released on ack.
        initial begin
            int   seen [2];
            logic ack_s [2];
            logic gnt_s [2];
            logic go;
            for (int m = 0; m < 2; m++) begin
                seen[m] = 0; pend[m] = 1'b0; req[m] = 1'b0;
                addr[m] = '0; wdata[m] = '0; wstrb[m] = '0;
            end
            forever begin
                @(negedge clk);
                ack_s[0] = bus.m0_ack;
                ack_s[1] = bus.m1_ack;
                gnt_s[0] = bus.busy && (bus.owner == 1'b0);
                gnt_s[1] = bus.busy && (bus.owner == 1'b1);
                @(posedge clk);
                #1;
                for (int m = 0; m < 2; m++) begin
                    if (rst) begin
                        pend[m] = 1'b0;
                        req[m]  = 1'b0;
                    end else begin
                        if (ack_s[m]) pend[m] = 1'b0;
                        if (pend[m] && gnt_s[m] &&
                            ((mode == MD_DIR) ? dir_drop[m] : (mode == MD_RAND && $urandom_range(0, 5) == 0))) begin
                            req[m]  = 1'b0;
                            addr[m] = $urandom;
                        end
                        if (!pend[m]) begin
                            req[m] = 1'b0;
                            go     = 1'b0;
                            case (mode)
                                MD_RAND: begin
                                    go       = ($urandom_range(0, 2) != 0);
                                    addr[m]  = $urandom;
                                    wdata[m] = $urandom;
                                    wstrb[m] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                                end
                                MD_BOTHRD: begin
                                    go       = 1'b1;
                                    addr[m]  = $urandom;
                                    wdata[m] = $urandom;
                                    wstrb[m] = 4'h0;
                                end
                                MD_DIR: begin
                                    if (dir_seq[m] != seen[m]) begin
                                        seen[m]  = dir_seq[m];
                                        go       = 1'b1;
                                        addr[m]  = dir_addr[m];
                                        wdata[m] = dir_wdata[m];
                                        wstrb[m] = dir_wstrb[m];
                                    end
                                end
                                default: ;
                            endcase
                            if (go) begin
                                req[m]  = 1'b1;
                                pend[m] = 1'b1;
                            end
                        end
                    end
                end
            end
        end

        // Slave: data valid only in the single cycle RD_LATENCY after the strobe.
        int          sq_due [$];
        logic [31:0] sq_dat [$];
        initial forever begin
            @(negedge clk);
            if (rst) begin
                sq_due.delete();
                sq_dat.delete();
            end else if (bus.s_rstrb) begin
                sq_due.push_back(cyc + L);
                sq_dat.push_back(slave_data(bus.s_addr));
            end
        end
        initial begin
            sl_rdata = 32'hBAD0_0000;
            forever begin
                @(posedge clk);
                #1;
                while (sq_due.size() != 0 && sq_due[0] < cyc) begin
                    void'(sq_due.pop_front());
                    void'(sq_dat.pop_front());
                end
                if (sq_due.size() != 0 && sq_due[0] == cyc) sl_rdata = sq_dat[0];
                else sl_rdata = 32'hBAD0_0000 ^ 32'(cyc);
            end
        end

        // Reference model: grant decided from the arbitration rules, timing from
        // the latency rules, expressed as absolute cycle numbers.
        exp_t qs [$];
        exp_t qa [$];
        logic last_m  = 1'b1;
        logic own_m   = 1'b0;
        int   free_at = 0;
        int   busy_lo = 1;
        int   busy_hi = 0;
        initial forever begin
            exp_t e;
            logic w;
            int   ack_at;
            @(negedge clk);
            if (rst) begin
                qs.delete();
                qa.delete();
                last_m  = 1'b1;
                free_at = 0;
                busy_lo = 1;
                busy_hi = 0;
            end else if (cyc >= free_at && (req[0] || req[1])) begin
                if (req[0] && req[1]) w = (FP != 0) ? 1'b0 : ~last_m;
                else                  w = req[1];
                e.m     = w;
                e.addr  = addr[w];
                e.wdata = wdata[w];
                e.wstrb = wstrb[w];
                e.rdata = (wstrb[w] != 0) ? 32'h0 : slave_data(addr[w]);
                e.cyc   = cyc + 1;
                qs.push_back(e);
                ack_at  = cyc + 2 + ((wstrb[w] != 0) ? 0 : L);
                e.cyc   = ack_at;
                qa.push_back(e);
                free_at = ack_at + 1;
                busy_lo = cyc + 1;
                busy_hi = ack_at;
                own_m   = w;
                last_m  = w;
            end
        end

        // Monitor: compares whatever the DUT presents against the queued predictions.
        initial forever begin
            exp_t e;
            logic sev, aev, due, exp_busy;
            @(negedge clk);
            if (rst) begin
                chk("reset_zero", g,
                    |{bus.s_addr, bus.s_wdata, bus.s_wstrb, bus.s_rstrb, bus.m0_ack, bus.m0_rdata,
                      bus.m1_ack, bus.m1_rdata, bus.owner, bus.busy}, 1'b0);
            end else begin
                exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
                chk("busy", g, bus.busy, exp_busy);
                if (exp_busy) chk("owner", g, bus.owner, own_m);

                sev = bus.s_rstrb || (bus.s_wstrb != 0);
                due = (qs.size() != 0) && (qs[0].cyc <= cyc);
                if (sev || due) begin
                    chk("strobe_when", g, {sev, due}, 2'b11);
                    if (due) begin
                        e = qs.pop_front();
                        if (sev) begin
                            chk("strobe_cyc", g, cyc, e.cyc);
                            chk("s_addr", g, bus.s_addr, e.addr);
                            chk("s_wdata", g, bus.s_wdata, e.wdata);
                            chk("s_wstrb", g, bus.s_wstrb, e.wstrb);
                            chk("s_rstrb", g, bus.s_rstrb, e.wstrb == 4'h0);
                        end
                    end
                end

                aev = bus.m0_ack || bus.m1_ack;
                due = (qa.size() != 0) && (qa[0].cyc <= cyc);
                if (aev || due) begin
                    chk("ack_when", g, {aev, due}, 2'b11);
                    if (due) begin
                        e = qa.pop_front();
                        if (aev) begin
                            chk("ack_cyc", g, cyc, e.cyc);
                            chk("ack_who", g, {bus.m1_ack, bus.m0_ack}, e.m ? 2'b10 : 2'b01);
                            chk("rdata_owner", g, e.m ? bus.m1_rdata : bus.m0_rdata, e.rdata);
                            chk("rdata_other", g, e.m ? bus.m0_rdata : bus.m1_rdata, 32'h0);
                            chk("s_addr_hold", g, bus.s_addr, e.addr);
                        end
                    end
                end
            end
        end
    end

    function automatic int outstanding();
        return int'(ge[0].pend[0]) + int'(ge[0].pend[1]) + ge[0].qa.size() +
               int'(ge[1].pend[0]) + int'(ge[1].pend[1]) + ge[1].qa.size() +
               int'(ge[2].pend[0]) + int'(ge[2].pend[1]) + ge[2].qa.size();
    endfunction

    task automatic issue(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        dir_addr[m]  = a;
        dir_wdata[m] = d;
        dir_wstrb[m] = s;
        dir_seq[m]   = dir_seq[m] + 1;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        repeat (2) @(posedge clk);
        while (outstanding() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk({"drain_", nm}, -1, outstanding(), 0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            dir_seq[m] = 0; dir_addr[m] = '0; dir_wdata[m] = '0; dir_wstrb[m] = '0; dir_drop[m] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        mode = MD_DIR;
        issue(0, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
        drain("m0_write");
        issue(1, 32'h0000_0010, 32'h0, 4'h0);
        drain("m1_read");

        mode = MD_BOTHRD;
        repeat (40) @(posedge clk);
        #2 mode = MD_DIR;
        drain("both_read");

        mode = MD_RAND;
        repeat (400) @(posedge clk);
        #2 mode = MD_DIR;
        drain("random");

        dir_drop[0] = 1'b1;
        issue(0, 32'h0000_0020, 32'h0, 4'h0);
        drain("drop_req");
        dir_drop[0] = 1'b0;

        issue(0, 32'h0000_0030, 32'h0, 4'h0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        issue(0, 32'h0000_0040, 32'h0, 4'h0);
        issue(1, 32'h0000_0044, 32'h0, 4'h0);
        drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100us;
        $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
